bcd_counter_scan: RTL and testbench
===================================

# bcd_counter_scan

Two-digit BCD up/down counter with a time-multiplexed display scanner. It drives the shared 4-bit code input of the 7-segment decoder and the digit-select lines of a 2-digit common display. It counts 00–99 on enable ticks and wraps in both directions. On each wrap it shows a status message for a programmable number of ticks: "UP" on overflow, "L0" on underflow. It emits decoder codes 0–12 only: 10 = U, 11 = P, 12 = L.

## Interface
Parameters:
- SCAN_W, 16: width of the scan counter; each digit is shown for 2^SCAN_W clocks.
- MSG_TICKS, 4: number of en ticks a wrap message is held; legal range 1–15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count tick, one-clock pulse.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only with en.
- clear  in  1  synchronous clear of counter and message.
- bcd  out  4  code to the 7-segment decoder, registered.
- digit_sel  out  2  one-hot active-high digit enable: 2'b01 = ones, 2'b10 = tens; registered.
- tens  out  4  current tens digit, 0–9.
- ones  out  4  current ones digit, 0–9.
- msg_active  out  1  high while a wrap message is displayed.

## Operation
- State machine has two states: COUNT and MSG. It also holds a msg_kind register (UP or LO) and a 4-bit msg_timer.
- Priority per cycle, highest first: reset, clear, en. reset and clear have the same effect on counter and message state. clear does not reset the scanner.
- COUNT, en=1, up=1:
  - ones < 9 → ones+1.
  - ones = 9, tens < 9 → ones=0, tens+1.
  - 99 → 00, go to MSG with kind UP, msg_timer = MSG_TICKS.
- COUNT, en=1, up=0:
  - ones > 0 → ones−1.
  - ones = 0, tens > 0 → ones=9, tens−1.
  - 00 → 99, go to MSG with kind LO, msg_timer = MSG_TICKS.
- MSG:
  - Counter is frozen at its wrapped value and up is ignored.
  - Each en decrements msg_timer.
  - en with msg_timer = 1 → COUNT. Counting resumes on the next en, not the same one.
- Display codes:
  - COUNT: tens slot = tens, ones slot = ones.
  - MSG/UP: tens slot = 10, ones slot = 11.
  - MSG/LO: tens slot = 12, ones slot = 0.
  - Leading zeros are shown; there is no blanking.
- Scanner:
  - The SCAN_W-bit free-running counter increments every clock.
  - When it is all-ones, digit_sel toggles between 01 and 10 on the next edge.
  - bcd is loaded every clock with the code for the slot digit_sel selects after that edge. bcd and digit_sel therefore always change together and always match.
- msg_active = (state == MSG), registered.
- Digits never leave 0–9; any out-of-range value is unreachable.

## Timing
- Reset values: tens=0, ones=0, state=COUNT, msg_timer=0, scan counter=0, digit_sel=2'b01, bcd=0, msg_active=0.
- Counter latency: en sampled at edge N; tens, ones, and msg_active are updated after edge N.
- Display latency: bcd reflects a digit or state change one clock later (edge N+1). Worst case a slot is first visible 2^SCAN_W+1 clocks after the change.
- Scan period: 2^(SCAN_W+1) clocks for both digits. The first toggle to tens is after edge 2^SCAN_W following reset release.
- Simultaneous clear and en: clear wins, result 00/COUNT.
- clear or reset during MSG: immediate return to COUNT at 00, msg_active=0 after that edge.
- en held high continuously is legal: one step per clock. A 99→00 wrap with MSG_TICKS=4 ends MSG after 4 further clocks.
- The 4-bit msg_timer must reach the full MSG_TICKS range of 1–15.

## Test plan
- Reset then 99 up-ticks:
  - tens/ones read 98, then 99 on tick 99.
  - bcd/digit_sel show 9 on 01 and 9 on 10 (SCAN_W=2 for sim).
- From 99, one up-tick → tens=0, ones=0, msg_active=1, bcd alternates 11 on digit_sel 01 and 10 on 10. After 4 more en → msg_active=0, display 0/0. Next en → 01.
- From 00, one down-tick → 99, msg_active=1, display 0 on 01 and 12 on 10. After MSG_TICKS en, down-tick → 98.
- Ones-to-tens carry and borrow: 09 up → 10; 10 down → 09; 19 up → 20. The up input is ignored while en=0.
- clear asserted together with en at 57 → 00. clear mid-MSG → 00, msg_active=0 next cycle. Scanner phase is continuous across clear.
- reset asserted mid-count at 42 with scan mid-period → all outputs at reset values next cycle, digit_sel=01, bcd=0.

Source files
------------

// File: rtl/bcd_counter_scan.sv
// Two-digit BCD up/down counter with wrap messages ("UP"/"L0") and a
// time-multiplexed scanner driving a shared 7-segment decoder input.
module bcd_counter_scan #(
  parameter int SCAN_W    = 16,
  parameter int MSG_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       clear,
  output logic [3:0] bcd,
  output logic [1:0] digit_sel,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       msg_active
);

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_MSG   = 1'b1
  } state_t;

  typedef enum logic {
    KIND_UP = 1'b0,
    KIND_LO = 1'b1
  } kind_t;

  localparam logic [3:0]        MSG_LOAD  = 4'(MSG_TICKS);
  localparam logic [SCAN_W-1:0] SCAN_LAST = '1;
  localparam logic [3:0]        CODE_U    = 4'd10;
  localparam logic [3:0]        CODE_P    = 4'd11;
  localparam logic [3:0]        CODE_L    = 4'd12;

  state_t            state, state_next;
  kind_t             msg_kind, msg_kind_next;
  logic [3:0]        msg_timer, msg_timer_next;
  logic [3:0]        tens_next, ones_next;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        sel_next;
  logic [3:0]        tens_code, ones_code, code_next;

  // Counter / message FSM: clear outranks en; counting resumes only on
  // the en after the one that retires the message.
  always_comb begin
    state_next     = state;
    msg_kind_next  = msg_kind;
    msg_timer_next = msg_timer;
    tens_next      = tens;
    ones_next      = ones;
    if (clear) begin
      state_next     = ST_COUNT;
      msg_kind_next  = KIND_UP;
      msg_timer_next = 4'd0;
      tens_next      = 4'd0;
      ones_next      = 4'd0;
    end else if (en) begin
      case (state)
        ST_COUNT: begin
          if (up) begin
            if (ones < 4'd9) begin
              ones_next = ones + 4'd1;
            end else if (tens < 4'd9) begin
              ones_next = 4'd0;
              tens_next = tens + 4'd1;
            end else begin
              ones_next      = 4'd0;
              tens_next      = 4'd0;
              state_next     = ST_MSG;
              msg_kind_next  = KIND_UP;
              msg_timer_next = MSG_LOAD;
            end
          end else begin
            if (ones > 4'd0) begin
              ones_next = ones - 4'd1;
            end else if (tens > 4'd0) begin
              ones_next = 4'd9;
              tens_next = tens - 4'd1;
            end else begin
              ones_next      = 4'd9;
              tens_next      = 4'd9;
              state_next     = ST_MSG;
              msg_kind_next  = KIND_LO;
              msg_timer_next = MSG_LOAD;
            end
          end
        end
        ST_MSG: begin
          msg_timer_next = msg_timer - 4'd1;
          // A zero timer is unreachable; leaving on it avoids a stuck message.
          if (msg_timer <= 4'd1) begin
            msg_timer_next = 4'd0;
            state_next     = ST_COUNT;
          end
        end
        default: state_next = ST_COUNT;
      endcase
    end
  end

  // Slot codes come from the current registers, so the display trails a
  // counter change by one clock.
  always_comb begin
    tens_code = tens;
    ones_code = ones;
    if (state == ST_MSG) begin
      if (msg_kind == KIND_UP) begin
        tens_code = CODE_U;
        ones_code = CODE_P;
      end else begin
        tens_code = CODE_L;
        ones_code = 4'd0;
      end
    end
  end

  // bcd is loaded for the slot that digit_sel will select after this edge.
  always_comb begin
    sel_next = digit_sel;
    if (scan_cnt == SCAN_LAST) begin
      sel_next = {digit_sel[0], digit_sel[1]};
    end
    code_next = (sel_next == 2'b10) ? tens_code : ones_code;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_COUNT;
      msg_kind   <= KIND_UP;
      msg_timer  <= 4'd0;
      tens       <= 4'd0;
      ones       <= 4'd0;
      msg_active <= 1'b0;
      scan_cnt   <= '0;
      digit_sel  <= 2'b01;
      bcd        <= 4'd0;
    end else begin
      state      <= state_next;
      msg_kind   <= msg_kind_next;
      msg_timer  <= msg_timer_next;
      tens       <= tens_next;
      ones       <= ones_next;
      msg_active <= (state_next == ST_MSG);
      scan_cnt   <= scan_cnt + SCAN_W'(1);
      digit_sel  <= sel_next;
      bcd        <= code_next;
    end
  end

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Scoreboard bench for bcd_counter_scan: drivers queue expected count and
// display values; a negedge monitor pops and compares them.
module tb_bcd_counter_scan;

  localparam int SCAN_W    = 2;
  localparam int MSG_TICKS = 4;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       clear;
  logic [3:0] bcd;
  logic [1:0] digit_sel;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       msg_active;

  bcd_counter_scan #(.SCAN_W(SCAN_W), .MSG_TICKS(MSG_TICKS)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear),
    .bcd(bcd), .digit_sel(digit_sel), .tens(tens), .ones(ones),
    .msg_active(msg_active)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [8:0] exp_q[$];   // {msg_active, tens, ones}
  logic [7:0] disp_q[$];  // {tens slot code, ones slot code}
  logic       cnt_valid;
  logic       disp_valid;
  logic [1:0] seen;
  int         n_checks;
  int         n_errors;
  int unsigned edges_since_reset;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic logic [8:0] pk(input int m, input int t, input int o);
    return {1'(m), 4'(t), 4'(o)};
  endfunction

  // Edges since the last reset edge, used to predict the scan phase.
  always @(posedge clk) begin
    if (reset) edges_since_reset <= 0;
    else       edges_since_reset <= edges_since_reset + 1;
  end

  // Monitor
  always @(negedge clk) begin
    logic [8:0] e;
    logic [7:0] d;
    logic [1:0] exp_sel;
    if (cnt_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL count_queue: empty, got %0d%0d", tens, ones);
      end else begin
        e = exp_q.pop_front();
        check("count", {7'd0, msg_active, tens, ones}, {7'd0, e});
      end
    end
    if (disp_valid) begin
      if (disp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL disp_queue: empty, got bcd %0d", bcd);
      end else begin
        d = disp_q.pop_front();
        exp_sel = ((edges_since_reset >> SCAN_W) & 1) != 0 ? 2'b10 : 2'b01;
        check("digit_sel", {14'd0, digit_sel}, {14'd0, exp_sel});
        check("bcd", {12'd0, bcd}, {12'd0, (exp_sel == 2'b10) ? d[7:4] : d[3:0]});
        seen = seen | exp_sel;
      end
    end
  end

  // Driver tasks
  task automatic tick(input logic e, input logic u, input logic c, input logic [8:0] exp);
    en = e; up = u; clear = c;
    @(posedge clk); #1;
    en = 1'b0; clear = 1'b0;
    exp_q.push_back(exp);
    cnt_valid = 1'b1;
    @(negedge clk); #1;
    cnt_valid = 1'b0;
  endtask

  task automatic show(input logic [3:0] tcode, input logic [3:0] ocode);
    seen = 2'b00;
    repeat ((1 << (SCAN_W + 1)) + 2) begin
      @(posedge clk); #1;
      disp_q.push_back({tcode, ocode});
      disp_valid = 1'b1;
      @(negedge clk); #1;
      disp_valid = 1'b0;
    end
    check("both_slots_scanned", {14'd0, seen}, 16'd3);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_digit_sel", {14'd0, digit_sel}, 16'd1);
    check("reset_bcd", {12'd0, bcd}, 16'd0);
    exp_q.push_back(pk(0, 0, 0));
    cnt_valid = 1'b1;
    @(negedge clk); #1;
    cnt_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b0; clear = 1'b0;
    cnt_valid = 1'b0; disp_valid = 1'b0; seen = 2'b00;
    n_checks = 0; n_errors = 0;

    do_reset();

    // 99 up-ticks, then the display shows 99
    for (int i = 1; i <= 99; i++) tick(1, 1, 0, pk(0, i / 10, i % 10));
    show(4'd9, 4'd9);

    // Overflow to 00 with "UP", held for MSG_TICKS en; up ignored in MSG
    tick(1, 1, 0, pk(1, 0, 0));
    show(4'd10, 4'd11);
    tick(1, 0, 0, pk(1, 0, 0));
    tick(1, 1, 0, pk(1, 0, 0));
    tick(1, 0, 0, pk(1, 0, 0));
    tick(1, 1, 0, pk(0, 0, 0));
    show(4'd0, 4'd0);
    tick(1, 1, 0, pk(0, 0, 1));

    // Underflow to 99 with "L0"
    tick(1, 0, 0, pk(0, 0, 0));
    tick(1, 0, 0, pk(1, 9, 9));
    show(4'd12, 4'd0);
    for (int i = 1; i < MSG_TICKS; i++) tick(1, 1, 0, pk(1, 9, 9));
    tick(1, 1, 0, pk(0, 9, 9));
    tick(1, 0, 0, pk(0, 9, 8));

    // Carry and borrow; up ignored while en low
    tick(0, 0, 1, pk(0, 0, 0));
    for (int i = 1; i <= 9; i++) tick(1, 1, 0, pk(0, 0, i));
    tick(0, 1, 0, pk(0, 0, 9));
    tick(1, 1, 0, pk(0, 1, 0));
    tick(1, 0, 0, pk(0, 0, 9));
    for (int i = 10; i <= 57; i++) tick(1, 1, 0, pk(0, i / 10, i % 10));

    // clear wins over en at 57; scan phase continues across clear
    tick(1, 1, 1, pk(0, 0, 0));
    show(4'd0, 4'd0);

    // clear in the middle of a message
    tick(1, 0, 0, pk(1, 9, 9));
    tick(1, 0, 0, pk(1, 9, 9));
    tick(0, 0, 1, pk(0, 0, 0));
    show(4'd0, 4'd0);

    // reset mid-count at 42 with the scanner mid-period
    for (int i = 1; i <= 42; i++) tick(1, 1, 0, pk(0, i / 10, i % 10));
    tick(0, 0, 0, pk(0, 4, 2));
    tick(0, 1, 0, pk(0, 4, 2));
    do_reset();
    show(4'd0, 4'd0);

    check("exp_q_drained", 16'(exp_q.size()), 16'd0);
    check("disp_q_drained", 16'(disp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
